// File: rtl/muldiv_unit_pkg.sv
// Shared op encodings and default latencies for the multiply/divide unit.
package muldiv_unit_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W           = 4;

  // Ops that occupy the unit for a countdown period
  function automatic logic is_long_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_unit_core.sv
// Combinational multiply/divide datapath: produces {hi, lo} for one op plus a divide-by-zero flag.
module muldiv_unit_core
  import muldiv_unit_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [63:0] o_result,
  output logic        o_div_by_zero
);

  logic [63:0] w_sprod;
  logic [63:0] w_uprod;
  logic        w_signed_div;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_q_signed;
  logic [31:0] w_r_signed;

  assign w_sprod = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
  assign w_uprod = {32'd0, i_a} * {32'd0, i_b};

  // Signed division runs on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000
  assign w_signed_div = (i_op == MD_DIV);
  assign w_a_mag      = (w_signed_div && i_a[31]) ? (~i_a + 32'd1) : i_a;
  assign w_b_mag      = (w_signed_div && i_b[31]) ? (~i_b + 32'd1) : i_b;
  assign w_q_mag      = (w_b_mag == 32'd0) ? 32'd0 : (w_a_mag / w_b_mag);
  assign w_r_mag      = (w_b_mag == 32'd0) ? 32'd0 : (w_a_mag % w_b_mag);
  assign w_q_signed   = (i_a[31] ^ i_b[31]) ? (~w_q_mag + 32'd1) : w_q_mag;
  assign w_r_signed   = i_a[31] ? (~w_r_mag + 32'd1) : w_r_mag;

  always_comb begin
    o_result      = 64'd0;
    o_div_by_zero = 1'b0;
    case (i_op)
      MD_MULT:  o_result = w_sprod;
      MD_MULTU: o_result = w_uprod;
      MD_DIV: begin
        o_result      = {w_r_signed, w_q_signed};
        o_div_by_zero = (i_b == 32'd0);
      end
      MD_DIVU: begin
        o_result      = {w_r_mag, w_q_mag};
        o_div_by_zero = (i_b == 32'd0);
      end
      default: o_result = 64'd0;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// E-stage multiply/divide unit: HI/LO registers, latency countdown and D-stage stall request.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        instr_D_muldiv,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_pend_hi;
  logic [31:0]      r_pend_lo;
  logic             r_pend_dbz;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;

  logic [63:0]      w_result;
  logic             w_dbz;
  logic             w_accept;
  logic             w_long;
  logic             w_commit;

  muldiv_unit_core u_core (
    .i_op          (op),
    .i_a           (a),
    .i_b           (b),
    .o_result      (w_result),
    .o_div_by_zero (w_dbz)
  );

  assign busy     = (r_cnt != '0);
  assign w_accept = start & ~busy;
  assign w_long   = is_long_op(op);
  // Commit is only possible while busy, so it never collides with an accepted MTHI/MTLO
  assign w_commit = (r_cnt == CNT_W'(1)) & ~r_pend_dbz;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt      <= '0;
      r_pend_hi  <= '0;
      r_pend_lo  <= '0;
      r_pend_dbz <= 1'b0;
    end else if (w_accept && w_long) begin
      r_pend_hi  <= w_result[63:32];
      r_pend_lo  <= w_result[31:0];
      r_pend_dbz <= w_dbz;
      r_cnt      <= is_div_op(op) ? DIV_LOAD : MULT_LOAD;
    end else if (busy) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_commit) begin
      r_hi <= r_pend_hi;
      r_lo <= r_pend_lo;
    end else if (w_accept && (op == MD_MTHI)) begin
      r_hi <= a;
    end else if (w_accept && (op == MD_MTLO)) begin
      r_lo <= a;
    end
  end

  assign stall = instr_D_muldiv & (busy | (start & w_long));
  assign hi    = r_hi;
  assign lo    = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, results, stall, ignored issues and async reset.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        instr_D_muldiv;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;

  muldiv_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .op             (op),
    .a              (a),
    .b              (b),
    .instr_D_muldiv (instr_D_muldiv),
    .busy           (busy),
    .stall          (stall),
    .hi             (hi),
    .lo             (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    tick();
    start = 1'b0;
    op    = MD_NONE;
  endtask

  initial begin
    reset_n        = 1'b0;
    start          = 1'b0;
    op             = MD_NONE;
    a              = 32'd0;
    b              = 32'd0;
    instr_D_muldiv = 1'b1;
    tick();
    tick();
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    reset_n = 1'b1;
    tick();

    // MULT -1 * 2, stall asserted in the issue cycle
    op = MD_MULT; a = 32'hFFFFFFFF; b = 32'd2; start = 1'b1;
    #1;
    chk("mult_issue_stall", {31'd0, stall}, 32'd1);
    tick();
    start = 1'b0; op = MD_NONE;
    for (int i = 0; i < 5; i++) begin
      chk("mult_busy", {31'd0, busy}, 32'd1);
      chk("mult_busy_stall", {31'd0, stall}, 32'd1);
      chk("mult_hi_precommit", hi, 32'h0);
      tick();
    end
    chk("mult_done_busy", {31'd0, busy}, 32'd0);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFE);

    // MULTU same operands
    issue(MD_MULTU, 32'hFFFFFFFF, 32'd2);
    for (int i = 0; i < 5; i++) begin
      chk("multu_busy", {31'd0, busy}, 32'd1);
      chk("multu_hi_old", hi, 32'hFFFFFFFF);
      tick();
    end
    chk("multu_done_busy", {31'd0, busy}, 32'd0);
    chk("multu_hi", hi, 32'h00000001);
    chk("multu_lo", lo, 32'hFFFFFFFE);

    // start on the edge where counter goes 1->0 is ignored (busy was 1 when sampled)
    issue(MD_MULT, 32'd3, 32'd3);
    repeat (4) tick();
    chk("b2b_busy_last", {31'd0, busy}, 32'd1);
    op = MD_MULT; a = 32'd7; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0; op = MD_NONE;
    chk("b2b_busy_after", {31'd0, busy}, 32'd0);
    chk("b2b_lo", lo, 32'd9);
    chk("b2b_hi", hi, 32'd0);
    tick();
    chk("b2b_lo_hold", lo, 32'd9);

    // DIV -7 / 2 with D-stage not muldiv; stray starts during busy
    instr_D_muldiv = 1'b0;
    issue(MD_DIV, 32'hFFFFFFF9, 32'd2);
    for (int i = 0; i < 10; i++) begin
      chk("div_busy", {31'd0, busy}, 32'd1);
      chk("div_nostall", {31'd0, stall}, 32'd0);
      if (i == 3) begin
        op = MD_MTHI; a = 32'hDEAD; start = 1'b1;
      end else if (i == 5) begin
        op = MD_MULT; a = 32'd2; b = 32'd2; start = 1'b1;
      end
      tick();
      start = 1'b0; op = MD_NONE;
      if (i < 9) chk("div_hi_unchanged", hi, 32'd0);
    end
    chk("div_done_busy", {31'd0, busy}, 32'd0);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);

    // MTHI/MTLO: no busy, no stall
    instr_D_muldiv = 1'b1;
    op = MD_MTHI; a = 32'h1234; start = 1'b1;
    #1;
    chk("mthi_nostall", {31'd0, stall}, 32'd0);
    tick();
    start = 1'b0; op = MD_NONE;
    chk("mthi_hi", hi, 32'h1234);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    issue(MD_MTLO, 32'h5678, 32'd0);
    chk("mtlo_lo", lo, 32'h5678);
    chk("mtlo_hi_keep", hi, 32'h1234);

    // DIVU by zero: full latency, HI/LO untouched
    issue(MD_DIVU, 32'd99, 32'd0);
    for (int i = 0; i < 10; i++) begin
      chk("dbz_busy", {31'd0, busy}, 32'd1);
      tick();
    end
    chk("dbz_done_busy", {31'd0, busy}, 32'd0);
    chk("dbz_hi", hi, 32'h1234);
    chk("dbz_lo", lo, 32'h5678);

    // Signed overflow case
    issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
    repeat (10) tick();
    chk("ovf_lo", lo, 32'h80000000);
    chk("ovf_hi", hi, 32'h0);

    // MD_NONE is a no-op
    issue(MD_NONE, 32'hFFFF, 32'd1);
    chk("none_busy", {31'd0, busy}, 32'd0);
    chk("none_lo", lo, 32'h80000000);
    chk("none_hi", hi, 32'h0);

    // Async reset in the middle of a DIV
    issue(MD_MTHI, 32'h55AA, 32'd0);
    chk("pre_rst_hi", hi, 32'h55AA);
    issue(MD_DIV, 32'd100, 32'd7);
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hi", hi, 32'h0);
    chk("arst_lo", lo, 32'h0);
    tick();
    reset_n = 1'b1;
    repeat (12) tick();
    chk("arst_nocommit_hi", hi, 32'h0);
    chk("arst_nocommit_lo", lo, 32'h0);
    chk("arst_nocommit_busy", {31'd0, busy}, 32'd0);
    issue(MD_MTLO, 32'hABCD, 32'd0);
    chk("post_rst_mtlo", lo, 32'hABCD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
